// File: rtl/change_dispenser.sv
`default_nettype none
// change_dispenser: item-release strobe plus greedy 50/20/10 coin ejection, one-entry request slot, ack timeout. Rev 1.0
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       purchase,
  input  logic [2:0] ret,
  output logic       vend,
  input  logic       vend_ack,
  output logic       coin_valid,
  output logic [1:0] coin_sel,
  input  logic       coin_ack,
  output logic       busy,
  output logic [7:0] coins_out,
  output logic       overflow,
  output logic       bad_code,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE = 2'd0, VEND = 2'd1, COIN = 2'd2} state_t;

  state_t     state;
  logic [3:0] rem;
  logic       pend_valid;
  logic       pend_purchase;
  logic [3:0] pend_rem;
  logic [7:0] tcnt;

  logic       req;
  logic [3:0] req_rem;
  logic       take_any;
  logic       take_purchase;
  logic [3:0] take_rem;
  logic [3:0] coin_units;
  logic [3:0] rem_after;
  logic       timed_out;

  function automatic logic [1:0] sel_of(input logic [3:0] r);
    if (r >= 4'd5)      return 2'b11;
    else if (r >= 4'd2) return 2'b10;
    else if (r == 4'd1) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    req_rem = 4'd0;
    case (ret)
      3'd1:    req_rem = 4'd2;
      3'd2:    req_rem = 4'd3;
      3'd3:    req_rem = 4'd4;
      3'd4:    req_rem = 4'd5;
      3'd5:    req_rem = 4'd7;
      3'd6:    req_rem = 4'd9;
      default: req_rem = 4'd0;
    endcase
  end

  always_comb begin
    coin_units = 4'd0;
    case (coin_sel)
      2'b11:   coin_units = 4'd5;
      2'b10:   coin_units = 4'd2;
      2'b01:   coin_units = 4'd1;
      default: coin_units = 4'd0;
    endcase
  end

  // A queued request always has priority over the one on the current edge.
  assign req           = purchase | (ret != 3'b000);
  assign take_any      = pend_valid | req;
  assign take_purchase = pend_valid ? pend_purchase : purchase;
  assign take_rem      = pend_valid ? pend_rem : req_rem;
  assign rem_after     = rem - coin_units;
  assign timed_out     = ({1'b0, tcnt} + 9'd1) >= 9'(ACK_TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rem           <= 4'd0;
      pend_valid    <= 1'b0;
      pend_purchase <= 1'b0;
      pend_rem      <= 4'd0;
      tcnt          <= 8'd0;
      vend          <= 1'b0;
      coin_valid    <= 1'b0;
      coin_sel      <= 2'b00;
      busy          <= 1'b0;
      coins_out     <= 8'd0;
      overflow      <= 1'b0;
      bad_code      <= 1'b0;
      fault         <= 1'b0;
    end else begin
      if (ret == 3'b111) bad_code <= 1'b1;

      if (state == IDLE) begin
        if (pend_valid) begin
          pend_valid    <= req;
          pend_purchase <= purchase;
          pend_rem      <= req_rem;
        end
      end else if (req) begin
        if (pend_valid) begin
          overflow <= 1'b1;
        end else begin
          pend_valid    <= 1'b1;
          pend_purchase <= purchase;
          pend_rem      <= req_rem;
        end
      end

      case (state)
        IDLE: begin
          tcnt <= 8'd0;
          if (take_any && take_purchase) begin
            state <= VEND;
            vend  <= 1'b1;
            busy  <= 1'b1;
            rem   <= take_rem;
          end else if (take_any && take_rem != 4'd0) begin
            state      <= COIN;
            coin_valid <= 1'b1;
            coin_sel   <= sel_of(take_rem);
            busy       <= 1'b1;
            rem        <= take_rem;
          end
        end
        VEND: begin
          if (vend_ack) begin
            vend <= 1'b0;
            tcnt <= 8'd0;
            if (rem != 4'd0) begin
              state      <= COIN;
              coin_valid <= 1'b1;
              coin_sel   <= sel_of(rem);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (timed_out) begin
            state <= IDLE;
            fault <= 1'b1;
            rem   <= 4'd0;
            vend  <= 1'b0;
            busy  <= 1'b0;
            tcnt  <= 8'd0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        COIN: begin
          if (coin_ack) begin
            tcnt      <= 8'd0;
            coins_out <= coins_out + 8'd1;
            rem       <= rem_after;
            coin_sel  <= sel_of(rem_after);
            if (rem_after == 4'd0) begin
              state      <= IDLE;
              coin_valid <= 1'b0;
              busy       <= 1'b0;
            end
          end else if (timed_out) begin
            state      <= IDLE;
            fault      <= 1'b1;
            rem        <= 4'd0;
            coin_valid <= 1'b0;
            coin_sel   <= 2'b00;
            busy       <= 1'b0;
            tcnt       <= 8'd0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// tb_change_dispenser: directed scenarios plus random traffic against a cents-level transaction model.
module tb_change_dispenser;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       purchase = 1'b0;
  logic [2:0] ret = 3'd0;
  logic       vend_ack = 1'b0;
  logic       coin_ack = 1'b0;
  logic       vend, coin_valid, busy, overflow, bad_code, fault;
  logic [1:0] coin_sel;
  logic [7:0] coins_out;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model: one active transaction (mode 0 idle, 1 vending, 2 paying) and a one-deep queue.
  int m_mode, m_cents, m_wait, m_coins;
  bit m_qv, m_qp;
  int m_qc;
  bit m_ovf, m_bad, m_fault;

  change_dispenser #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .purchase(purchase), .ret(ret),
    .vend(vend), .vend_ack(vend_ack), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .coin_ack(coin_ack), .busy(busy), .coins_out(coins_out),
    .overflow(overflow), .bad_code(bad_code), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int ret_cents(input logic [2:0] r);
    case (r)
      3'd1: return 20;
      3'd2: return 30;
      3'd3: return 40;
      3'd4: return 50;
      3'd5: return 70;
      3'd6: return 90;
      default: return 0;
    endcase
  endfunction

  function automatic int next_coin(input int c);
    if (c >= 50) return 50;
    if (c >= 20) return 20;
    if (c >= 10) return 10;
    return 0;
  endfunction

  function automatic int sel_code(input int coin);
    case (coin)
      50: return 3;
      20: return 2;
      10: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cents = 0; m_wait = 0; m_coins = 0;
    m_qv = 0; m_qp = 0; m_qc = 0;
    m_ovf = 0; m_bad = 0; m_fault = 0;
  endtask

  task automatic model_begin(input bit p, input int c);
    m_wait = 0;
    if (p)           begin m_mode = 1; m_cents = c; end
    else if (c != 0) begin m_mode = 2; m_cents = c; end
    else             begin m_mode = 0; m_cents = 0; end
  endtask

  task automatic model_wait();
    m_wait++;
    if (m_wait >= TO) begin
      m_fault = 1; m_cents = 0; m_mode = 0; m_wait = 0;
    end
  endtask

  task automatic model_step();
    bit req;
    int c;
    req = purchase || (ret != 3'd0);
    c = ret_cents(ret);
    if (ret == 3'd7) m_bad = 1;
    if (m_mode == 0) begin
      if (m_qv) begin
        model_begin(m_qp, m_qc);
        m_qv = req; m_qp = purchase; m_qc = c;
      end else if (req) begin
        model_begin(purchase, c);
      end
    end else begin
      if (req) begin
        if (m_qv) m_ovf = 1;
        else begin m_qv = 1; m_qp = purchase; m_qc = c; end
      end
      if (m_mode == 1) begin
        if (vend_ack) begin m_mode = (m_cents != 0) ? 2 : 0; m_wait = 0; end
        else model_wait();
      end else begin
        if (coin_ack) begin
          m_cents -= next_coin(m_cents);
          m_coins++;
          m_wait = 0;
          if (m_cents == 0) m_mode = 0;
        end else model_wait();
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("vend", 32'(vend), 32'(m_mode == 1));
        check("coin_valid", 32'(coin_valid), 32'(m_mode == 2));
        check("coin_sel", 32'(coin_sel), (m_mode == 2) ? 32'(sel_code(next_coin(m_cents))) : 32'd0);
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("coins_out", 32'(coins_out), 32'(m_coins & 255));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("bad_code", 32'(bad_code), 32'(m_bad));
        check("fault", 32'(fault), 32'(m_fault));
      end
    end
  end

  task automatic step(input bit p, input logic [2:0] r, input bit va, input bit ca);
    purchase = p; ret = r; vend_ack = va; coin_ack = ca;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    purchase = 0; ret = 0; vend_ack = 0; coin_ack = 0;
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_coins", 32'(coins_out), 32'd0);
    check("rst_vend", 32'(vend), 32'd0);
    reset = 1;
    cmp_en = 1;

    // purchase with 90 change: vend, then 50, 20, 20
    step(1, 3'd6, 0, 0);
    check("s1_vend", 32'(vend), 32'd1);
    step(0, 3'd0, 1, 0);
    check("s1_sel50", 32'(coin_sel), 32'd3);
    step(0, 3'd0, 0, 1);
    check("s1_sel20a", 32'(coin_sel), 32'd2);
    step(0, 3'd0, 0, 1);
    check("s1_sel20b", 32'(coin_sel), 32'd2);
    step(0, 3'd0, 0, 1);
    check("s1_coins", 32'(coins_out), 32'd3);
    check("s1_busy", 32'(busy), 32'd0);

    // 30 change with ack held: 20 then 10
    do_reset();
    step(0, 3'd2, 0, 1);
    check("s2_sel20", 32'(coin_sel), 32'd2);
    step(0, 3'd0, 0, 1);
    check("s2_sel10", 32'(coin_sel), 32'd1);
    step(0, 3'd0, 0, 1);
    check("s2_coins", 32'(coins_out), 32'd2);
    check("s2_busy", 32'(busy), 32'd0);

    // three back-to-back requests: one queued, one dropped
    do_reset();
    step(0, 3'd1, 0, 0);
    step(0, 3'd1, 0, 0);
    step(0, 3'd1, 0, 0);
    check("s3_ovf", 32'(overflow), 32'd1);
    step(0, 3'd0, 0, 1);
    check("s3_idle", 32'(busy), 32'd0);
    step(0, 3'd0, 0, 0);
    check("s3_second", 32'(coin_sel), 32'd2);
    step(0, 3'd0, 0, 1);
    check("s3_coins", 32'(coins_out), 32'd2);
    step(0, 3'd0, 0, 0);
    check("s3_done", 32'(busy), 32'd0);

    // invalid code with purchase
    do_reset();
    step(1, 3'd7, 0, 0);
    check("s4_bad", 32'(bad_code), 32'd1);
    check("s4_vend", 32'(vend), 32'd1);
    step(0, 3'd0, 1, 0);
    check("s4_nocoin", 32'(coin_valid), 32'd0);

    // timeout on an unacknowledged 50 coin
    do_reset();
    step(0, 3'd4, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("s5_hold", 32'(coin_valid), 32'd1);
      step(0, 3'd0, 0, 0);
    end
    check("s5_hold4", 32'(coin_valid), 32'd1);
    step(0, 3'd0, 0, 0);
    check("s5_fault", 32'(fault), 32'd1);
    check("s5_sel", 32'(coin_sel), 32'd0);
    check("s5_idle", 32'(busy), 32'd0);

    // request on the final-ack edge waits one idle cycle
    do_reset();
    step(0, 3'd1, 0, 0);
    step(0, 3'd1, 0, 1);
    check("s6_idle", 32'(busy), 32'd0);
    step(0, 3'd0, 0, 0);
    check("s6_start", 32'(coin_valid), 32'd1);

    // asynchronous reset in the middle of a payout
    do_reset();
    step(0, 3'd5, 0, 0);
    step(0, 3'd0, 0, 1);
    #2 reset = 0;
    #1;
    check("s7_valid", 32'(coin_valid), 32'd0);
    check("s7_sel", 32'(coin_sel), 32'd0);
    check("s7_coins", 32'(coins_out), 32'd0);
    check("s7_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1;
    step(0, 3'd1, 0, 0);
    check("s7_after", 32'(coin_sel), 32'd2);

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      purchase = ($urandom_range(0, 7) == 0);
      ret = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      vend_ack = ($urandom_range(0, 2) != 0);
      coin_ack = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 0;
        #1 reset = 1;
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
